nibble_serial_adder: RTL

//  Sequencer that adds two WIDTH-bit operands four bits per cycle through an external 4-bit

---
 rtl/nibble_serial_adder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands four bits per cycle through an external
// 4-bit ripple-carry stage, registering the carry between slices.
module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             result_cout,
   output logic [3:0]       add_a,
   output logic [3:0]       add_b,
   output logic             add_cin,
   input  logic [3:0]       add_sum,
   input  logic             add_cout
);

   localparam int NSLICE = WIDTH / 4;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [IW-1:0]    r_idx;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             w_last;
   logic [3:0]       w_a;
   logic [3:0]       w_b;
   logic             w_cin;

   assign w_last = (r_idx == IW'(NSLICE - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (in_valid) w_next = S_RUN;
         S_RUN:  if (w_last) w_next = S_DONE;
         S_DONE: if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_carry  <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a      <= op_a;
                  r_b      <= op_b;
                  r_carry  <= op_cin;
                  r_idx    <= '0;
                  r_result <= '0;
               end
            end
            S_RUN: begin
               for (int s = 0; s < NSLICE; s++) begin
                  if (r_idx == IW'(s)) r_result[4*s +: 4] <= add_sum;
               end
               r_carry <= add_cout;
               if (w_last) r_cout <= add_cout;
               else        r_idx  <= r_idx + IW'(1);
            end
            default: ;
         endcase
      end
   end

   // Slice select is a one-hot compare so no variable part-select is needed
   always_comb begin
      w_a   = '0;
      w_b   = '0;
      w_cin = 1'b0;
      if (r_state == S_RUN) begin
         w_cin = r_carry;
         for (int s = 0; s < NSLICE; s++) begin
            if (r_idx == IW'(s)) begin
               w_a = r_a[4*s +: 4];
               w_b = r_b[4*s +: 4];
            end
         end
      end
   end

   assign add_a       = w_a;
   assign add_b       = w_b;
   assign add_cin     = w_cin;
   assign in_ready    = (r_state == S_IDLE);
   assign out_valid   = (r_state == S_DONE);
   assign result      = r_result;
   assign result_cout = r_cout;

endmodule
